// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU slice.
// Op encodings, FSM states and default operand width.
package alu_pkg;

   localparam int W_DEF = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative mul/div datapath: shift-add multiply, restoring divide.
// acc_nxt is the post-step value so the owner can latch it on the last step.
module alu_iter_core
   import alu_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           step,
   input  logic           is_div,
   input  logic [CW-1:0]  cnt,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] acc_nxt
);

   logic [2*W-1:0] acc;
   logic [2*W-1:0] a_ext;
   logic [W:0]     rem_sh;
   logic [W-1:0]   rem_sub;

   assign a_ext   = {{W{1'b0}}, a};
   // Divide: upper half is remainder, lower half shifts dividend out / quotient in
   assign rem_sh  = {acc[2*W-1:W], acc[W-1]};
   assign rem_sub = rem_sh[W-1:0] - b;

   always_comb begin
      acc_nxt = acc;
      if (start) begin
         acc_nxt = is_div ? a_ext : '0;
      end else if (step) begin
         if (is_div) begin
            if (rem_sh >= {1'b0, b})
               acc_nxt = {rem_sub, acc[W-2:0], 1'b1};
            else
               acc_nxt = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
         end else if (b[cnt]) begin
            acc_nxt = acc + (a_ext << cnt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else
         acc <= acc_nxt;
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU: add/sub in one cycle, mul/div over W cycles.
// Owns the request/response FSM; the iterative core does mul/div.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic [1:0]     op,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [2*W-1:0] re,
   output logic           div0
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_e         state, state_nxt;
   op_e            op_q;
   logic [W-1:0]   a_q, b_q;
   logic [CW-1:0]  cnt;
   logic           accept, last;
   logic [2*W-1:0] sum, dif, core_nxt;
   logic [W-1:0]   core_a, core_b;
   logic           core_div;

   assign accept = req_valid && req_ready;
   assign last   = !op_q[1] || (cnt == CW'(W - 1));
   assign sum    = {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
   assign dif    = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};

   // Core loads from the live inputs on the accept edge, then from the captures
   assign core_a   = (state == IDLE) ? a : a_q;
   assign core_b   = (state == IDLE) ? b : b_q;
   assign core_div = (state == IDLE) ? (op == OP_DIV) : (op_q == OP_DIV);

   alu_iter_core #(
      .W  (W),
      .CW (CW)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .start   (accept),
      .step    (state == CALC),
      .is_div  (core_div),
      .cnt     (cnt),
      .a       (core_a),
      .b       (core_b),
      .acc_nxt (core_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      res_valid = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_nxt = CALC;
         end
         CALC: begin
            if (last)
               state_nxt = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= OP_ADD;
         cnt  <= '0;
         re   <= '0;
         div0 <= 1'b0;
      end else begin
         if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op_e'(op);
            cnt  <= '0;
         end
         if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (last) begin
               unique case (op_q)
                  OP_ADD:  re <= sum;
                  OP_SUB:  re <= dif;
                  default: re <= core_nxt;
               endcase
               div0 <= (op_q == OP_DIV) && (b_q == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases then random traffic.
// Expected results come from a plain-arithmetic reference function.
module tb_alu_seq_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] a, b;
   logic [1:0] op;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] re;
   logic       div0;

   int n_chk  = 0;
   int n_fail = 0;

   alu_seq_unit #(.W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .re        (re),
      .div0      (div0)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_re(logic [3:0] x, logic [3:0] y,
                                         logic [1:0] o);
      int ia = int'(x);
      int ib = int'(y);
      case (o)
         2'd0:    return 8'(ia + ib);
         2'd1:    return 8'(ia - ib);
         2'd2:    return 8'(ia * ib);
         default: begin
            if (ib == 0) return {x, 4'hF};
            return 8'((ia % ib) * 16 + ia / ib);
         end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [3:0] ta, input logic [3:0] tb_,
                      input logic [1:0] top, input int stall);
      logic [7:0] exp_re;
      int         lat;
      int         w;
      exp_re = ref_re(ta, tb_, top);
      a = ta;
      b = tb_;
      op = top;
      req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 50) begin
         tick();
         w++;
      end
      chk("accept_wait", w, 0);
      tick();
      req_valid = 1'b0;
      a = 4'($urandom);
      b = 4'($urandom);
      op = 2'($urandom);
      res_ready = (stall == 0);
      chk("calc_busy", req_ready, 1'b0);
      lat = 0;
      while (!res_valid && lat < 50) begin
         tick();
         lat++;
      end
      chk("latency", lat + 1, top[1] ? 5 : 2);
      chk("re", re, exp_re);
      chk("div0", div0, (top == 2'd3) && (tb_ == 4'd0));
      for (int i = 0; i < stall; i++) begin
         req_valid = 1'b1;
         tick();
         chk("stall_valid", res_valid, 1'b1);
         chk("stall_re", re, exp_re);
         chk("stall_rdy", req_ready, 1'b0);
      end
      req_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      chk("valid_drop", res_valid, 1'b0);
      chk("idle_rdy", req_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      res_ready = 1'b1;
      a = '0;
      b = '0;
      op = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_re", re, 8'h00);
      chk("rst_div0", div0, 1'b0);

      run(4'hC, 4'hB, 2'd0, 0);
      chk("add_c_b", re, 8'h17);
      run(4'hC, 4'hB, 2'd1, 0);
      chk("sub_c_b", re, 8'h01);
      run(4'hB, 4'hC, 2'd1, 0);
      chk("sub_wrap", re, 8'hFF);
      run(4'hC, 4'hB, 2'd2, 0);
      chk("mul_c_b", re, 8'h84);
      run(4'hF, 4'hF, 2'd2, 0);
      chk("mul_f_f", re, 8'hE1);
      run(4'hC, 4'hB, 2'd3, 0);
      chk("div_c_b", re, 8'h11);
      run(4'h9, 4'h0, 2'd3, 0);
      chk("div0_re", re, 8'h9F);
      chk("div0_flag", div0, 1'b1);

      run(4'hC, 4'hB, 2'd2, 10);
      run(4'h7, 4'h5, 2'd0, 0);

      // Abort a multiply on its second CALC cycle
      a = 4'hD;
      b = 4'h7;
      op = 2'd2;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", res_valid, 1'b0);
      chk("abort_rdy", req_ready, 1'b1);
      chk("abort_re", re, 8'h00);
      chk("abort_div0", div0, 1'b0);
      run(4'h6, 4'h3, 2'd0, 0);

      for (int i = 0; i < 40; i++)
         run(4'($urandom), 4'($urandom), 2'($urandom),
             int'($urandom_range(0, 2)));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
